// File: rtl/cds_rnm_pkg.sv
// Shared sizing, FSM state encoding and helper functions for clock_distribution_ctrl.
// Segment order is therm 0..16 followed by bin 0..5 and finally bin bit 6.
package cds_rnm_pkg;

   localparam int NUM_THERM = 17;
   localparam int NUM_BIN   = 7;
   localparam int NUM_SEG   = 24;
   localparam int SEG_CNT_W = 5;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_SETTLE = 3'd1,
      ST_RAMP   = 3'd2,
      ST_RUN    = 3'd3,
      ST_RAMPDN = 3'd4,
      ST_FAULT  = 3'd5
   } state_e;

   // Enable mask with the lowest cnt segments set.
   function automatic logic [NUM_SEG-1:0] prefix_mask(input logic [SEG_CNT_W-1:0] cnt);
      logic [NUM_SEG-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_SEG; i++) begin
         m[i] = (SEG_CNT_W'(i) < cnt);
      end
      return m;
   endfunction

   function automatic logic [1:0] atb_scan_next(input logic [1:0] code);
      logic [1:0] n;
      case (code)
         2'b01:   n = 2'b10;
         2'b10:   n = 2'b11;
         default: n = 2'b01;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/clock_distribution_ctrl_if.sv
// Control/status bundle between the supervisor and clock_distribution_ctrl.
// atb_scan exists only when CLKDIST_ATB_SCAN_EN is defined.
interface clock_distribution_ctrl_if;
   import cds_rnm_pkg::*;

   logic                 start;
   logic                 stop;
   logic                 supply_ok;
   logic                 fault_clr;
   logic [1:0]           atb_req;
`ifdef CLKDIST_ATB_SCAN_EN
   logic                 atb_scan;
`endif
   logic                 pdb;
   logic [1:0]           atb_ena;
   logic [NUM_THERM-1:0] seg_en_therm;
   logic [NUM_BIN-1:0]   seg_en_bin;
   logic                 ready;
   logic                 fault;
   logic [2:0]           state;

   modport slave (
`ifdef CLKDIST_ATB_SCAN_EN
      input  atb_scan,
`endif
      input  start, stop, supply_ok, fault_clr, atb_req,
      output pdb, atb_ena, seg_en_therm, seg_en_bin, ready, fault, state
   );

   modport master (
`ifdef CLKDIST_ATB_SCAN_EN
      output atb_scan,
`endif
      output start, stop, supply_ok, fault_clr, atb_req,
      input  pdb, atb_ena, seg_en_therm, seg_en_bin, ready, fault, state
   );

endinterface

// File: rtl/clkdist_seg_ramp.sv
// Saturating segment-enable counter (0..NUM_SEG) with registered prefix mask.
// Clear wins over a step; a step moves one segment up or down.
module clkdist_seg_ramp
   import cds_rnm_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 step_i,
   input  logic                 up_i,
   output logic [SEG_CNT_W-1:0] count_o,
   output logic [NUM_SEG-1:0]   mask_o
);

   logic [SEG_CNT_W-1:0] count_q;
   logic [SEG_CNT_W-1:0] count_d;
   logic [NUM_SEG-1:0]   mask_q;

   // Next count, saturating at both ends so the mask stays a valid prefix.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (step_i && up_i && (count_q < SEG_CNT_W'(NUM_SEG))) begin
         count_d = count_q + SEG_CNT_W'(1);
      end else if (step_i && !up_i && (count_q != '0)) begin
         count_d = count_q - SEG_CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count and mask registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         mask_q  <= '0;
      end else begin
         count_q <= count_d;
         mask_q  <= prefix_mask(count_d);
      end
   end

   assign count_o = count_q;
   assign mask_o  = mask_q;

endmodule

// File: rtl/clock_distribution_ctrl.sv
// Power sequencer for the clock distribution: bias settle, segment ramp up/down, fault hold.
// Optional feature macro: CLKDIST_ATB_SCAN_EN (test-bus code scan in RUN).
module clock_distribution_ctrl
   import cds_rnm_pkg::*;
#(
   parameter int SETTLE_CYCLES = 64,
   parameter int RAMP_CYCLES   = 4,
   parameter int ATB_DWELL     = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   clock_distribution_ctrl_if.slave   bus
);

   // One shared timer serves settle, ramp step spacing and scan dwell.
   localparam int TMAX_A  = (SETTLE_CYCLES > RAMP_CYCLES) ? SETTLE_CYCLES : RAMP_CYCLES;
   localparam int TMAX    = (TMAX_A > ATB_DWELL) ? TMAX_A : ATB_DWELL;
   localparam int TIMER_W = $clog2(TMAX + 1);

   localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RAMP_LAST   = TIMER_W'(RAMP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DWELL_LAST  = TIMER_W'(ATB_DWELL - 1);

   state_e               state_q;
   state_e               state_d;
   logic [TIMER_W-1:0]   timer_q;
   logic [TIMER_W-1:0]   timer_d;
   logic                 pdb_q;
   logic                 pdb_d;
   logic                 ready_q;
   logic                 ready_d;
   logic                 fault_q;
   logic                 fault_d;
   logic [1:0]           atb_q;
   logic [1:0]           atb_d;
`ifdef CLKDIST_ATB_SCAN_EN
   logic                 scan_q;
   logic                 scan_d;
`endif

   logic                 ramp_clr_s;
   logic                 ramp_step_s;
   logic                 ramp_up_s;
   logic [SEG_CNT_W-1:0] ramp_cnt_s;
   logic [NUM_SEG-1:0]   seg_mask_s;

   clkdist_seg_ramp u_seg_ramp (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (ramp_clr_s),
      .step_i  (ramp_step_s),
      .up_i    (ramp_up_s),
      .count_o (ramp_cnt_s),
      .mask_o  (seg_mask_s)
   );

   // Next-state, timer, ramp control and next registered outputs.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      ramp_clr_s  = 1'b0;
      ramp_step_s = 1'b0;
      ramp_up_s   = 1'b1;

      case (state_q)
         ST_OFF: begin
            ramp_clr_s = 1'b1;
            timer_d    = '0;
            if (bus.start && !bus.stop && bus.supply_ok) begin
               state_d = ST_SETTLE;
            end else begin
               state_d = ST_OFF;
            end
         end
         ST_SETTLE: begin
            if (!bus.supply_ok) begin
               state_d    = ST_FAULT;
               ramp_clr_s = 1'b1;
               timer_d    = '0;
            end else if (bus.stop) begin
               state_d = ST_OFF;
               timer_d = '0;
            end else if (timer_q == SETTLE_LAST) begin
               state_d     = ST_RAMP;
               timer_d     = '0;
               ramp_step_s = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_RAMP: begin
            if (!bus.supply_ok) begin
               state_d    = ST_FAULT;
               ramp_clr_s = 1'b1;
               timer_d    = '0;
            end else if (bus.stop) begin
               state_d     = ST_RAMPDN;
               timer_d     = '0;
               ramp_step_s = 1'b1;
               ramp_up_s   = 1'b0;
            end else if (timer_q == RAMP_LAST) begin
               timer_d = '0;
               if (ramp_cnt_s == SEG_CNT_W'(NUM_SEG)) begin
                  state_d = ST_RUN;
               end else begin
                  ramp_step_s = 1'b1;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_RUN: begin
            if (!bus.supply_ok) begin
               state_d    = ST_FAULT;
               ramp_clr_s = 1'b1;
               timer_d    = '0;
            end else if (bus.stop) begin
               state_d     = ST_RAMPDN;
               timer_d     = '0;
               ramp_step_s = 1'b1;
               ramp_up_s   = 1'b0;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RAMPDN: begin
            ramp_up_s = 1'b0;
            if (!bus.supply_ok) begin
               state_d    = ST_FAULT;
               ramp_clr_s = 1'b1;
               timer_d    = '0;
            end else if (timer_q == RAMP_LAST) begin
               timer_d = '0;
               if (ramp_cnt_s == '0) begin
                  state_d = ST_OFF;
               end else begin
                  ramp_step_s = 1'b1;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_FAULT: begin
            ramp_clr_s = 1'b1;
            timer_d    = '0;
            if (bus.fault_clr) begin
               state_d = ST_OFF;
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            state_d    = ST_OFF;
            ramp_clr_s = 1'b1;
            timer_d    = '0;
         end
      endcase

      pdb_d   = (state_d == ST_SETTLE) || (state_d == ST_RAMP) ||
                (state_d == ST_RUN)    || (state_d == ST_RAMPDN);
      ready_d = (state_d == ST_RUN);
      fault_d = (state_d == ST_FAULT);
      atb_d   = 2'b00;
`ifdef CLKDIST_ATB_SCAN_EN
      scan_d  = 1'b0;
`endif

      // Test-bus select is only driven while running.
      if (state_d == ST_RUN) begin
`ifdef CLKDIST_ATB_SCAN_EN
         if (bus.atb_scan) begin
            scan_d = 1'b1;
            if (!scan_q) begin
               atb_d   = 2'b01;
               timer_d = '0;
            end else if (timer_q == DWELL_LAST) begin
               atb_d   = atb_scan_next(atb_q);
               timer_d = '0;
            end else begin
               atb_d   = atb_q;
               timer_d = timer_q + TIMER_W'(1);
            end
         end else begin
            atb_d = bus.atb_req;
         end
`else
         atb_d = bus.atb_req;
`endif
      end else begin
         atb_d = 2'b00;
      end
   end

   // State, timer and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         timer_q <= '0;
         pdb_q   <= 1'b0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         atb_q   <= 2'b00;
`ifdef CLKDIST_ATB_SCAN_EN
         scan_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pdb_q   <= pdb_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
         atb_q   <= atb_d;
`ifdef CLKDIST_ATB_SCAN_EN
         scan_q  <= scan_d;
`endif
      end
   end

   assign bus.pdb          = pdb_q;
   assign bus.ready        = ready_q;
   assign bus.fault        = fault_q;
   assign bus.atb_ena      = atb_q;
   assign bus.state        = state_q;
   assign bus.seg_en_therm = seg_mask_s[NUM_THERM-1:0];
   assign bus.seg_en_bin   = seg_mask_s[NUM_SEG-1:NUM_THERM];

endmodule
